vga_renderer: RTL

VGA_RENDERER -- requirements
Module: vga_renderer

---
 rtl/vga_renderer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/vga_renderer.sv
// 640x480 VGA renderer: ball, two players, two goals and an optional time bar (macro TIME_BAR_EN).
// Colour, blank and syncs leave a two-stage pipeline clocked by the pixel tick (clk/2).
module vga_renderer #(
    parameter int PLAYER_RADIUS = 20,
    parameter int BALL_RADIUS   = 8,
    parameter int GOAL_RADIUS   = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [18:0] ball_hor_position,
    input  logic [18:0] ball_ver_position,
    input  logic [9:0]  team1_hor_position,
    input  logic [9:0]  team1_ver_position,
    input  logic [9:0]  team2_hor_position,
    input  logic [9:0]  team2_ver_position,
    input  logic [7:0]  time_left,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic [7:0]  rgb
);
    localparam logic [20:0] BALL_R2   = 21'(BALL_RADIUS * BALL_RADIUS);
    localparam logic [20:0] PLAYER_R2 = 21'(PLAYER_RADIUS * PLAYER_RADIUS);
    localparam logic [20:0] GOAL_R2   = 21'(GOAL_RADIUS * GOAL_RADIUS);
    localparam logic [9:0]  GOAL_L_X  = 10'(GOAL_RADIUS);
    localparam logic [9:0]  GOAL_R_X  = 10'(639 - GOAL_RADIUS);
    localparam logic [9:0]  GOAL_Y    = 10'd240;

    // Off-screen centres are never drawn, so no disc can wrap around the screen edge.
    function automatic logic in_disc(input logic [9:0] px, input logic [9:0] py,
                                     input logic [9:0] cx, input logic [9:0] cy,
                                     input logic [20:0] r2);
        logic [20:0] dx;
        logic [20:0] dy;
        dx = {11'd0, (px >= cx) ? (px - cx) : (cx - px)};
        dy = {11'd0, (py >= cy) ? (py - cy) : (cy - py)};
        return (cx <= 10'd639) && (cy <= 10'd479) && ((dx * dx + dy * dy) <= r2);
    endfunction

    logic       tick_q;
    logic       pix_tick;
    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;

    assign pix_tick = tick_q;

    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_tick) begin
            if (hcount_q == 10'd799) begin
                hcount_d = '0;
                vcount_d = (vcount_q == 10'd524) ? '0 : vcount_q + 10'd1;
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q   <= 1'b0;
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            tick_q   <= ~tick_q;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    logic       snap;
    logic [9:0] ball_x_q, ball_y_q, t1_x_q, t1_y_q, t2_x_q, t2_y_q;

    assign snap = pix_tick && (hcount_q == 10'd0) && (vcount_q == 10'd480);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ball_x_q <= '0;
            ball_y_q <= '0;
            t1_x_q   <= '0;
            t1_y_q   <= '0;
            t2_x_q   <= '0;
            t2_y_q   <= '0;
        end else if (snap) begin
            ball_x_q <= ball_hor_position[9:0];
            ball_y_q <= ball_ver_position[9:0];
            t1_x_q   <= team1_hor_position;
            t1_y_q   <= team1_ver_position;
            t2_x_q   <= team2_hor_position;
            t2_y_q   <= team2_ver_position;
        end
    end

    logic bar_hit;
    logic unused_bits;
`ifdef TIME_BAR_EN
    logic [7:0]  time_q;
    logic [10:0] bar_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    time_q <= '0;
        else if (snap) time_q <= time_left;
    end

    assign bar_len     = {2'b00, time_q, 1'b0} + {3'b000, time_q};
    assign bar_hit     = (vcount_q >= 10'd464) && (vcount_q <= 10'd479) && ({1'b0, hcount_q} < bar_len);
    assign unused_bits = ^{ball_hor_position[18:10], ball_ver_position[18:10]};
`else
    assign bar_hit     = 1'b0;
    assign unused_bits = ^{ball_hor_position[18:10], ball_ver_position[18:10], time_left};
`endif

    logic vld_p0, hs_p0, vs_p0, ball_p0, t1_p0, t2_p0, goal_p0;

    assign vld_p0  = (hcount_q < 10'd640) && (vcount_q < 10'd480);
    assign hs_p0   = !((hcount_q >= 10'd656) && (hcount_q <= 10'd751));
    assign vs_p0   = !((vcount_q >= 10'd490) && (vcount_q <= 10'd491));
    assign ball_p0 = in_disc(hcount_q, vcount_q, ball_x_q, ball_y_q, BALL_R2);
    assign t1_p0   = in_disc(hcount_q, vcount_q, t1_x_q, t1_y_q, PLAYER_R2);
    assign t2_p0   = in_disc(hcount_q, vcount_q, t2_x_q, t2_y_q, PLAYER_R2);
    assign goal_p0 = in_disc(hcount_q, vcount_q, GOAL_L_X, GOAL_Y, GOAL_R2)
                   | in_disc(hcount_q, vcount_q, GOAL_R_X, GOAL_Y, GOAL_R2);

    // Stage p1: registered hit flags and raw timing.
    logic vld_p1_q, hs_p1_q, vs_p1_q, ball_p1_q, t1_p1_q, t2_p1_q, goal_p1_q, bar_p1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q  <= 1'b0;
            hs_p1_q   <= 1'b1;
            vs_p1_q   <= 1'b1;
            ball_p1_q <= 1'b0;
            t1_p1_q   <= 1'b0;
            t2_p1_q   <= 1'b0;
            goal_p1_q <= 1'b0;
            bar_p1_q  <= 1'b0;
        end else if (pix_tick) begin
            vld_p1_q  <= vld_p0;
            hs_p1_q   <= hs_p0;
            vs_p1_q   <= vs_p0;
            ball_p1_q <= ball_p0;
            t1_p1_q   <= t1_p0;
            t2_p1_q   <= t2_p0;
            goal_p1_q <= goal_p0;
            bar_p1_q  <= bar_hit;
        end
    end

    logic [7:0] rgb_d;

    always_comb begin
        rgb_d = 8'h10;
        if (!vld_p1_q)      rgb_d = 8'h00;
        else if (ball_p1_q) rgb_d = 8'hFC;
        else if (t1_p1_q)   rgb_d = 8'hE0;
        else if (t2_p1_q)   rgb_d = 8'h03;
        else if (goal_p1_q) rgb_d = 8'hFF;
        else if (bar_p1_q)  rgb_d = 8'h1C;
    end

    // Stage p2: output registers, all four outputs move together.
    logic [7:0] rgb_p2_q;
    logic       blank_p2_q, hs_p2_q, vs_p2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_p2_q   <= 8'h00;
            blank_p2_q <= 1'b1;
            hs_p2_q    <= 1'b1;
            vs_p2_q    <= 1'b1;
        end else if (pix_tick) begin
            rgb_p2_q   <= rgb_d;
            blank_p2_q <= ~vld_p1_q;
            hs_p2_q    <= hs_p1_q;
            vs_p2_q    <= vs_p1_q;
        end
    end

    assign rgb   = rgb_p2_q;
    assign blank = blank_p2_q;
    assign hsync = hs_p2_q;
    assign vsync = vs_p2_q;
endmodule
